// File: rtl/hvac_actuator_sequencer_pkg.sv
// Shared encodings for the HVAC actuator sequencer.
// FSM state codes, run mode codes and state width.
package hvac_actuator_sequencer_pkg;

  localparam int STATE_W = 3;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_FAN_PRE  = 3'd1;
  localparam logic [2:0] ST_HEAT     = 3'd2;
  localparam logic [2:0] ST_COOL     = 3'd3;
  localparam logic [2:0] ST_FAN_POST = 3'd4;

  typedef enum logic [1:0] {
    MODE_NONE = 2'd0,
    MODE_HEAT = 2'd1,
    MODE_COOL = 2'd2
  } mode_t;

endpackage

// File: rtl/hvac_actuator_sequencer_down_counter.sv
// Loadable down-counter that saturates at zero.
// Ports: clk, rst_n, load, load_val, dec in; zero out.
module hvac_actuator_sequencer_down_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/hvac_actuator_sequencer.sv
// Sequences heater/cooler/fan from controller requests with pre/post fan run,
// min on-time, min off lockout and heat/cool exclusion. Ports: clk, rst_n,
// heating_req, cooling_req in; heater_on, cooler_on, fan_on, lockout,
// conflict, state_o out.
module hvac_actuator_sequencer
  import hvac_actuator_sequencer_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int PRE_CYC     = 4,
  parameter int MIN_ON_CYC  = 20,
  parameter int POST_CYC    = 8,
  parameter int MIN_OFF_CYC = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               heating_req,
  input  logic               cooling_req,
  output logic               heater_on,
  output logic               cooler_on,
  output logic               fan_on,
  output logic               lockout,
  output logic               conflict,
  output logic [STATE_W-1:0] state_o
);

  if (PRE_CYC < 1 || (64'(PRE_CYC) >> CNT_W) != 0) begin : g_bad_pre
    $error("PRE_CYC out of range");
  end
  if (MIN_ON_CYC < 1 || (64'(MIN_ON_CYC) >> CNT_W) != 0) begin : g_bad_on
    $error("MIN_ON_CYC out of range");
  end
  if (POST_CYC < 1 || (64'(POST_CYC) >> CNT_W) != 0) begin : g_bad_post
    $error("POST_CYC out of range");
  end
  if (MIN_OFF_CYC < 1 || (64'(MIN_OFF_CYC) >> CNT_W) != 0) begin : g_bad_off
    $error("MIN_OFF_CYC out of range");
  end

  localparam logic [CNT_W-1:0] PRE_LD  = CNT_W'(PRE_CYC - 1);
  localparam logic [CNT_W-1:0] ON_LD   = CNT_W'(MIN_ON_CYC - 1);
  localparam logic [CNT_W-1:0] POST_LD = CNT_W'(POST_CYC - 1);
  localparam logic [CNT_W-1:0] OFF_LD  = CNT_W'(MIN_OFF_CYC - 1);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] st_nxt;
  mode_t              mode;
  mode_t              mode_nxt;
  logic               run_ld;
  logic [CNT_W-1:0]   run_val;
  logic               run_zero;
  logic               off_ld;
  logic               off_zero;
  logic               req_lat;
  logic               req_opp;

  hvac_actuator_sequencer_down_counter #(.CNT_W(CNT_W)) u_run_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (run_ld),
    .load_val (run_val),
    .dec      (1'b1),
    .zero     (run_zero)
  );

  hvac_actuator_sequencer_down_counter #(.CNT_W(CNT_W)) u_off_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (off_ld),
    .load_val (OFF_LD),
    .dec      (1'b1),
    .zero     (off_zero)
  );

  // Requests seen relative to the mode latched at run start.
  assign req_lat = (mode == MODE_COOL) ? cooling_req : heating_req;
  assign req_opp = (mode == MODE_COOL) ? heating_req : cooling_req;

  always_comb begin
    st_nxt   = state;
    mode_nxt = mode;
    run_ld   = 1'b0;
    run_val  = '0;
    off_ld   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!lockout && (heating_req ^ cooling_req)) begin
          mode_nxt = heating_req ? MODE_HEAT : MODE_COOL;
          st_nxt   = ST_FAN_PRE;
          run_ld   = 1'b1;
          run_val  = PRE_LD;
        end
      end
      ST_FAN_PRE: begin
        if (run_zero) begin
          run_ld = 1'b1;
          if (req_lat && !req_opp) begin
            st_nxt  = (mode == MODE_COOL) ? ST_COOL : ST_HEAT;
            run_val = ON_LD;
          end else begin
            st_nxt  = ST_FAN_POST;
            run_val = POST_LD;
          end
        end
      end
      ST_HEAT, ST_COOL: begin
        if (run_zero && (!req_lat || req_opp)) begin
          st_nxt  = ST_FAN_POST;
          run_ld  = 1'b1;
          run_val = POST_LD;
        end
      end
      ST_FAN_POST: begin
        if (run_zero) begin
          st_nxt   = ST_IDLE;
          mode_nxt = MODE_NONE;
          off_ld   = 1'b1;
        end
      end
      default: begin
        st_nxt   = ST_IDLE;
        mode_nxt = MODE_NONE;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered alongside it,
  // so they track state exactly with no input-to-output path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mode      <= MODE_NONE;
      heater_on <= 1'b0;
      cooler_on <= 1'b0;
      fan_on    <= 1'b0;
      lockout   <= 1'b0;
      conflict  <= 1'b0;
    end else begin
      state     <= st_nxt;
      mode      <= mode_nxt;
      heater_on <= (st_nxt == ST_HEAT);
      cooler_on <= (st_nxt == ST_COOL);
      fan_on    <= (st_nxt != ST_IDLE);
      conflict  <= heating_req & cooling_req;
      if (off_ld) begin
        lockout <= 1'b1;
      end else if (off_zero) begin
        lockout <= 1'b0;
      end
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_hvac_actuator_sequencer.sv
// Directed scoreboard bench for hvac_actuator_sequencer.
// Expected output vectors are queued per cycle and popped after each edge.
module tb_hvac_actuator_sequencer;

  logic       clk;
  logic       rst_n;
  logic       heating_req;
  logic       cooling_req;
  logic       heater_on;
  logic       cooler_on;
  logic       fan_on;
  logic       lockout;
  logic       conflict;
  logic [2:0] state_o;

  // {state[2:0], heater, cooler, fan, lockout, conflict}
  localparam logic [7:0] E_IDLE   = 8'h00;
  localparam logic [7:0] E_IDLE_L = 8'h02;
  localparam logic [7:0] E_PRE    = 8'h24;
  localparam logic [7:0] E_HEAT   = 8'h54;
  localparam logic [7:0] E_COOL   = 8'h6C;
  localparam logic [7:0] E_POST   = 8'h84;
  localparam logic [7:0] CF       = 8'h01;

  typedef struct {
    string      tag;
    logic [7:0] v;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;

  hvac_actuator_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .heating_req (heating_req),
    .cooling_req (cooling_req),
    .heater_on   (heater_on),
    .cooler_on   (cooler_on),
    .fan_on      (fan_on),
    .lockout     (lockout),
    .conflict    (conflict),
    .state_o     (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string tag, input int n, input logic [7:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    for (int i = 0; i < n; i++) sb.push_back(e);
  endtask

  task automatic check_now();
    exp_t       e;
    logic [7:0] obs;
    obs = {state_o, heater_on, cooler_on, fan_on, lockout, conflict};
    checks++;
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL sb_empty obs=%h exp=<entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v) else begin
        fails++;
        $error("FAIL %s obs=%h exp=%h", e.tag, obs, e.v);
      end
    end
    checks++;
    assert (!(heater_on && cooler_on) && (fan_on || !(heater_on || cooler_on)))
    else begin
      fails++;
      $error("FAIL excl obs=h%b c%b f%b exp=no_overlap", heater_on, cooler_on, fan_on);
    end
  endtask

  task automatic run(input int n, input logic h, input logic c);
    heating_req = h;
    cooling_req = c;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check_now();
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    heating_req = 1'b0;
    cooling_req = 1'b0;
    #2;
    push("reset", 1, E_IDLE);
    check_now();
    #10 rst_n = 1'b1;
    push("idle", 1, E_IDLE);
    run(1, 1'b0, 1'b0);

    // pulse request: fan pre then post, no heater, then lockout
    push("t1_pre", 1, E_PRE);
    run(1, 1'b1, 1'b0);
    push("t1_pre", 3, E_PRE);
    push("t1_post", 8, E_POST);
    push("t1_lock", 10, E_IDLE_L);
    push("t1_idle", 1, E_IDLE);
    run(22, 1'b0, 1'b0);

    // held 40 cycles
    push("t2_pre", 4, E_PRE);
    push("t2_heat", 36, E_HEAT);
    run(40, 1'b1, 1'b0);
    push("t2_post", 8, E_POST);
    push("t2_lock", 10, E_IDLE_L);
    push("t2_idle", 1, E_IDLE);
    run(19, 1'b0, 1'b0);

    // short request still gets full min-on
    push("t3_pre", 4, E_PRE);
    push("t3_heat", 4, E_HEAT);
    run(8, 1'b1, 1'b0);
    push("t3_heat", 16, E_HEAT);
    push("t3_post", 8, E_POST);
    push("t3_lock", 10, E_IDLE_L);
    push("t3_idle", 1, E_IDLE);
    run(35, 1'b0, 1'b0);

    // heat run then immediate cooling request, blocked by lockout
    push("t4_pre", 4, E_PRE);
    push("t4_heat", 26, E_HEAT);
    run(30, 1'b1, 1'b0);
    push("t4_post", 8, E_POST);
    push("t4_lock", 10, E_IDLE_L);
    push("t4_idle", 1, E_IDLE);
    push("t4_cpre", 4, E_PRE);
    push("t4_cool", 17, E_COOL);
    run(40, 1'b0, 1'b1);
    push("t4_cool", 3, E_COOL);
    push("t4_cpost", 8, E_POST);
    push("t4_clock", 10, E_IDLE_L);
    push("t4_cidle", 1, E_IDLE);
    run(22, 1'b0, 1'b0);

    // both requests in idle
    push("t5_cf", 3, E_IDLE | CF);
    run(3, 1'b1, 1'b1);
    push("t5_cfclr", 1, E_IDLE);
    run(1, 1'b0, 1'b0);

    // cooling raised during heat
    push("t5_pre", 4, E_PRE);
    push("t5_heat", 6, E_HEAT);
    run(10, 1'b1, 1'b0);
    push("t5_heatcf", 14, E_HEAT | CF);
    push("t5_postcf", 6, E_POST | CF);
    run(20, 1'b1, 1'b1);
    push("t5_post", 2, E_POST);
    push("t5_lock", 10, E_IDLE_L);
    push("t5_idle", 1, E_IDLE);
    run(13, 1'b0, 1'b0);

    // reset mid-cool, then restart with request held
    push("t6_pre", 4, E_PRE);
    push("t6_cool", 6, E_COOL);
    run(10, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    push("t6_rst", 1, E_IDLE);
    check_now();
    #2 rst_n = 1'b1;
    push("t6_rpre", 4, E_PRE);
    push("t6_rcool", 3, E_COOL);
    run(7, 1'b0, 1'b1);
    push("t6_rcool", 17, E_COOL);
    push("t6_rpost", 8, E_POST);
    push("t6_rlock", 10, E_IDLE_L);
    push("t6_ridle", 1, E_IDLE);
    run(36, 1'b0, 1'b0);

    checks++;
    assert (sb.size() === 0) else begin
      fails++;
      $error("FAIL sb_drain obs=%0d exp=0", sb.size());
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
